// File: rtl/sec_tick_gen_if.sv
// Control/data bundle between a seconds-stage controller and sec_tick_gen.
// The master drives the mode and load controls; the slave returns seconds and pulses.
interface sec_tick_gen_if;
    logic       run;
    logic       load;
    logic [5:0] data;
    logic       step;
    logic       enable;
    logic [5:0] sec;
    logic [5:0] databus;
    logic       sec_tick;
    logic       min_tick;

    modport master (
        output run, load, data, step, enable,
        input  sec, databus, sec_tick, min_tick
    );

    modport slave (
        input  run, load, data, step, enable,
        output sec, databus, sec_tick, min_tick
    );
endinterface

// File: rtl/sec_tick_gen.sv
// Seconds stage: divides clk down to a 1 Hz tick, counts 0..59, and carries
// into the minute counter with a one-cycle min_tick on each run-mode wrap.
module sec_tick_gen #(
    parameter int DIV = 50000000,
    parameter int PW  = 26
) (
    input  logic          clk,
    input  logic          clear,
    sec_tick_gen_if.slave bus
);

    // Reject parameter sets the prescaler cannot represent.
    generate
        if (DIV < 1 || (64'd1 << PW) < 64'(DIV)) begin : g_bad_param
            $error("sec_tick_gen: need DIV >= 1 and 2**PW >= DIV");
        end
    endgenerate

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [5:0]    SEC_LAST   = 6'd59;

    logic [PW-1:0] presc_reg;
    logic [PW-1:0] presc_next;
    logic [5:0]    sec_reg;
    logic [5:0]    sec_next;
    logic          sec_tick_reg;
    logic          sec_tick_next;
    logic          min_tick_reg;
    logic          min_tick_next;
    logic          step_prev_reg;

    logic          tick;
    logic          step_edge;
    logic [5:0]    sec_inc;
    logic [5:0]    load_val;

    always_comb begin
        tick      = bus.run && (presc_reg == PRESC_LAST);
        step_edge = bus.step && !step_prev_reg;
        sec_inc   = (sec_reg == SEC_LAST) ? 6'd0 : sec_reg + 6'd1;
        // Out-of-range load values collapse to 0 so sec never leaves 0..59.
        load_val  = (bus.data > SEC_LAST) ? 6'd0 : bus.data;
    end

    // Priority: load, then set-mode step edge, then prescaler tick, else hold.
    always_comb begin
        sec_next      = sec_reg;
        presc_next    = presc_reg;
        sec_tick_next = 1'b0;
        min_tick_next = 1'b0;
        if (bus.load) begin
            sec_next   = load_val;
            presc_next = '0;
        end else if (step_edge && !bus.run) begin
            // Set mode never carries into the minute counter.
            sec_next = sec_inc;
        end else if (tick) begin
            sec_next      = sec_inc;
            presc_next    = '0;
            sec_tick_next = 1'b1;
            min_tick_next = (sec_reg == SEC_LAST);
        end else if (bus.run) begin
            presc_next = presc_reg + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            sec_reg       <= '0;
            presc_reg     <= '0;
            sec_tick_reg  <= 1'b0;
            min_tick_reg  <= 1'b0;
            step_prev_reg <= 1'b0;
        end else begin
            sec_reg       <= sec_next;
            presc_reg     <= presc_next;
            sec_tick_reg  <= sec_tick_next;
            min_tick_reg  <= min_tick_next;
            step_prev_reg <= bus.step;
        end
    end

    assign bus.sec      = sec_reg;
    assign bus.sec_tick = sec_tick_reg;
    assign bus.min_tick = min_tick_reg;
    assign bus.databus  = bus.enable ? sec_reg : 6'h00;

endmodule
